// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encodings,
// reset PC and the address-error exception code (also used by the PC stage).
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
    localparam logic [4:0]  EXC_ADEL = 5'h04;

    // A fetch address must be word aligned.
    function automatic logic misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/inst_fetch_buf.sv
// Output entry register presented to decode: valid/pc/inst/exc with
// load, clear (redirect) and consume (decode accepted) controls.
module fetch_buf #(
    parameter logic [31:0] RESET_PC = inst_fetch_pkg::RESET_PC,
    parameter logic [4:0]  EXC_ADEL = inst_fetch_pkg::EXC_ADEL
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic        consume,
    input  logic [31:0] ld_pc,
    input  logic [31:0] ld_inst,
    input  logic        ld_exc,
    output logic        valid,
    output logic [31:0] entry_pc,
    output logic [31:0] entry_inst,
    output logic        entry_exc,
    output logic [4:0]  entry_exccode
);

    logic        valid_r;
    logic [31:0] pc_r;
    logic [31:0] inst_r;
    logic        exc_r;
    logic [4:0]  exccode_r;

    // Entry register; pc/inst are kept after consumption, only valid drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r   <= 1'b0;
            pc_r      <= RESET_PC;
            inst_r    <= 32'h0000_0000;
            exc_r     <= 1'b0;
            exccode_r <= 5'h00;
        end else if (load) begin
            valid_r   <= 1'b1;
            pc_r      <= ld_pc;
            inst_r    <= ld_exc ? 32'h0000_0000 : ld_inst;
            exc_r     <= ld_exc;
            exccode_r <= ld_exc ? EXC_ADEL : 5'h00;
        end else if (clear || consume) begin
            valid_r   <= 1'b0;
        end else begin
            valid_r   <= valid_r;
        end
    end

    assign valid         = valid_r;
    assign entry_pc      = pc_r;
    assign entry_inst    = inst_r;
    assign entry_exc     = exc_r;
    assign entry_exccode = exccode_r;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch sequencer: one outstanding addr_ok/data_ok request,
// captures the word for decode, stalls the PC until the entry is consumed.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = inst_fetch_pkg::RESET_PC,
    parameter logic [4:0]  EXC_ADEL = inst_fetch_pkg::EXC_ADEL
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        flush,
    input  logic        id_stall,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        pc_stall,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_exc,
    output logic [4:0]  out_exccode
);

    import inst_fetch_pkg::*;

    fetch_state_e state_r;
    fetch_state_e next_state_s;
    logic [31:0]  req_pc_r;
    logic         inst_req_s;
    logic         latch_req_s;
    logic         buf_load_s;
    logic         buf_clear_s;
    logic         buf_consume_s;
    logic [31:0]  buf_ld_pc_s;
    logic [31:0]  buf_ld_inst_s;
    logic         buf_ld_exc_s;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_REQ;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Address of the accepted request, reported as the entry pc on data_ok.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_pc_r <= 32'h0000_0000;
        end else if (latch_req_s) begin
            req_pc_r <= pc;
        end else begin
            req_pc_r <= req_pc_r;
        end
    end

    // Next-state and control decode; data_ok outside WAIT/DROP is ignored.
    always_comb begin
        next_state_s  = state_r;
        inst_req_s    = 1'b0;
        latch_req_s   = 1'b0;
        buf_load_s    = 1'b0;
        buf_clear_s   = 1'b0;
        buf_consume_s = 1'b0;
        buf_ld_pc_s   = req_pc_r;
        buf_ld_inst_s = inst_rdata;
        buf_ld_exc_s  = 1'b0;
        case (state_r)
            ST_REQ: begin
                if (misaligned(pc)) begin
                    // A redirect replaces the bad pc, so no exception entry.
                    if (flush) begin
                        next_state_s = ST_REQ;
                    end else begin
                        buf_load_s    = 1'b1;
                        buf_ld_pc_s   = pc;
                        buf_ld_inst_s = 32'h0000_0000;
                        buf_ld_exc_s  = 1'b1;
                        next_state_s  = ST_HOLD;
                    end
                end else begin
                    inst_req_s = 1'b1;
                    if (inst_addr_ok) begin
                        latch_req_s  = 1'b1;
                        next_state_s = flush ? ST_DROP : ST_WAIT;
                    end else begin
                        next_state_s = ST_REQ;
                    end
                end
            end
            ST_WAIT: begin
                if (inst_data_ok) begin
                    if (flush) begin
                        next_state_s = ST_REQ;
                    end else begin
                        buf_load_s   = 1'b1;
                        next_state_s = ST_HOLD;
                    end
                end else if (flush) begin
                    next_state_s = ST_DROP;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    buf_clear_s  = 1'b1;
                    next_state_s = ST_REQ;
                end else if (!id_stall) begin
                    buf_consume_s = 1'b1;
                    next_state_s  = ST_REQ;
                end else begin
                    next_state_s = ST_HOLD;
                end
            end
            ST_DROP: begin
                if (inst_data_ok) begin
                    next_state_s = ST_REQ;
                end else begin
                    next_state_s = ST_DROP;
                end
            end
            default: begin
                next_state_s = ST_REQ;
            end
        endcase
    end

    assign inst_req  = inst_req_s;
    assign inst_addr = inst_req_s ? pc : 32'h0000_0000;
    assign pc_stall  = !((state_r == ST_HOLD) && !id_stall && !flush);

    fetch_buf #(
        .RESET_PC (RESET_PC),
        .EXC_ADEL (EXC_ADEL)
    ) u_fetch_buf (
        .clk           (clk),
        .rst           (rst),
        .load          (buf_load_s),
        .clear         (buf_clear_s),
        .consume       (buf_consume_s),
        .ld_pc         (buf_ld_pc_s),
        .ld_inst       (buf_ld_inst_s),
        .ld_exc        (buf_ld_exc_s),
        .valid         (out_valid),
        .entry_pc      (out_pc),
        .entry_inst    (out_inst),
        .entry_exc     (out_exc),
        .entry_exccode (out_exccode)
    );

endmodule
